// File: rtl/sound_pkg.sv
// Shared audio definitions: sound code constants, the request-queue FSM
// state type, and the event priority encoder. Also imported by the game
// FSM and the sound player so all three agree on code values.
package sound_pkg;

    localparam logic [2:0] SND_NONE     = 3'd0;
    localparam logic [2:0] SND_SELECT   = 3'd1;
    localparam logic [2:0] SND_DESELECT = 3'd2;
    localparam logic [2:0] SND_MOVE     = 3'd3;
    localparam logic [2:0] SND_CAPTURE  = 3'd4;
    localparam logic [2:0] SND_ILLEGAL  = 3'd5;
    localparam logic [2:0] SND_PROMOTE  = 3'd6;
    localparam logic [2:0] SND_GAMEOVER = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_GAP
    } snd_state_t;

    // Highest set event bit wins; bit i maps to code i+1, no bit -> SND_NONE.
    function automatic logic [2:0] snd_priority(input logic [6:0] ev);
        logic [2:0] code;
        code = SND_NONE;
        for (int i = 0; i < 7; i++) begin
            if (ev[i]) begin
                code = 3'(i + 1);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/sound_fifo.sv
// Small synchronous FIFO of 3-bit sound codes.
//   clk, rst      : clock, synchronous active-high reset
//   push_i        : write data_i at the tail (accepted if not full, or if
//                   a pop happens in the same cycle)
//   pop_i         : drop the head entry (ignored when empty)
//   ovr_i         : overwrite the newest entry with data_i (used when full)
//   flush_i       : empty the FIFO; wins over every other request
//   data_o        : current head entry (valid when !empty_o)
//   count_o/full_o/empty_o : occupancy status
module sound_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       ovr_i,
    input  logic                       flush_i,
    input  logic [2:0]                 data_i,
    output logic [2:0]                 data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop, do_ovr;
    logic [AW-1:0] tail_ptr;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == (AW+1)'(DEPTH));
    assign count_o  = count_q;
    // Head is read combinationally so the FSM can latch it in the same
    // cycle it decides to pop; the array is only a few entries deep.
    assign data_o   = mem[rd_ptr_q];
    // Pointers wrap naturally because DEPTH is a power of two.
    assign tail_ptr = wr_ptr_q - AW'(1);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign do_ovr  = ovr_i && full_o && !do_pop && !do_push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (!flush_i) begin
            if (do_push) begin
                mem[wr_ptr_q] <= data_i;
            end else if (do_ovr) begin
                mem[tail_ptr] <= data_i;
            end
        end
    end

endmodule

// File: rtl/sound_request_queue.sv
// Queues one-cycle sound events from the game logic and hands them to the
// sound player one at a time, waiting for the player's busy flag to rise
// and fall, then a quiet gap, before the next request.
//   clk, rst   : 100 MHz clock, synchronous active-high reset
//   ev         : event pulses, bit i-1 requests sound code i
//   mute       : level; flush queue and ignore events
//   start      : player busy flag
//   sound_code : code presented to the player (held until next request)
//   play_sound : one-cycle request pulse
//   busy       : FSM active or queue non-empty
//   q_count    : queue occupancy
//   dropped    : one-cycle pulse when an event is lost to a full queue
module sound_request_queue
    import sound_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int GAP_CYCLES  = 1000000,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [6:0]               ev,
    input  logic                     mute,
    input  logic                     start,
    output logic [2:0]               sound_code,
    output logic                     play_sound,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     dropped
);
    localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    snd_state_t state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    code_q;
    logic          play_q;
    logic          dropped_q;

    logic [2:0] cand;
    logic [2:0] head;
    logic       fifo_full, fifo_empty;
    logic       pop, push, ovr, dropped_d;

    assign cand = snd_priority(ev);

    // The head is taken in the IDLE cycle that launches a request, so the
    // latched code and the play pulse appear together in ISSUE.
    assign pop       = (state_q == ST_IDLE) && !fifo_empty && !mute;
    assign push      = !mute && (cand != SND_NONE) && (!fifo_full || pop);
    assign ovr       = !mute && (cand == SND_GAMEOVER) && fifo_full && !pop;
    assign dropped_d = !mute && (cand != SND_NONE) && (cand != SND_GAMEOVER)
                       && fifo_full && !pop;

    sound_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .ovr_i   (ovr),
        .flush_i (mute),
        .data_i  (cand),
        .data_o  (head),
        .count_o (q_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            code_q    <= SND_NONE;
            play_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= dropped_d;
            play_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        state_q <= ST_ISSUE;
                        code_q  <= head;
                        play_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_ISSUE: begin
                    // The ISSUE cycle counts toward the acknowledge timeout.
                    state_q <= ST_WAIT_ACK;
                    cnt_q   <= cnt_q + CW'(1);
                end
                ST_WAIT_ACK: begin
                    if (start) begin
                        state_q <= ST_WAIT_DONE;
                        cnt_q   <= '0;
                    end else if (cnt_q >= CW'(ACK_TIMEOUT - 1)) begin
                        // Entry is abandoned, not retried.
                        state_q <= ST_GAP;
                        cnt_q   <= CW'(1);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!start) begin
                        state_q <= ST_GAP;
                        cnt_q   <= CW'(1);
                    end
                end
                ST_GAP: begin
                    // Counter enters at 1: the transition cycle is already a
                    // quiet cycle, so the gap totals GAP_CYCLES clocks.
                    if (cnt_q >= CW'(GAP_CYCLES - 1)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign sound_code = code_q;
    assign play_sound = play_q;
    assign dropped    = dropped_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sound_request_queue.sv
module tb_sound_request_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] ev = '0;
    logic       mute = 1'b0;
    logic       start = 1'b0;
    logic [2:0] sound_code;
    logic       play_sound;
    logic       busy;
    logic [2:0] q_count;
    logic       dropped;

    int vectors = 0;
    int miscompares = 0;

    sound_request_queue #(
        .DEPTH(DEPTH),
        .GAP_CYCLES(8),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ev         (ev),
        .mute       (mute),
        .start      (start),
        .sound_code (sound_code),
        .play_sound (play_sound),
        .busy       (busy),
        .q_count    (q_count),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Push one event for exactly one cycle.
    task automatic pulse_ev(input logic [6:0] e);
        ev = e;
        tick();
        ev = '0;
    endtask

    task automatic wait_idle(input string name, output int plays);
        int i;
        plays = 0;
        i = 0;
        while (busy && i < 200) begin
            tick();
            if (play_sound) plays++;
            i++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, i);
        end
    endtask

    // Wait for the next request, check its code, then model a short sound.
    task automatic play_one(input logic [2:0] exp, input string name);
        int i;
        i = 0;
        while (play_sound !== 1'b1 && i < 60) begin
            tick();
            i++;
        end
        vectors++;
        if (play_sound !== 1'b1 || sound_code !== exp) begin
            miscompares++;
            $display("FAIL %s: play_sound=%b sound_code=%0d, required 1/%0d",
                     name, play_sound, sound_code, exp);
        end else begin
            $display("play %s: code=%0d after %0d cycles", name, sound_code, i);
        end
        tick();
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({sound_code, play_sound, busy, q_count, dropped} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset: code=%0d play=%b busy=%b q=%0d drop=%b, required all 0",
                     sound_code, play_sound, busy, q_count, dropped);
        end
        rst = 1'b0;
        tick();
        $display("reset: done");
    endtask

    task automatic test_single;
        int bad_play;
        pulse_ev(7'b0001000);                  // cycle N+1 now
        vectors++;
        if (q_count !== 3'd1 || play_sound !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_n1: q=%0d play=%b busy=%b, required 1/0/1",
                     q_count, play_sound, busy);
        end
        tick();                                // N+2
        vectors++;
        if (play_sound !== 1'b1 || sound_code !== 3'd4 || q_count !== 3'd0) begin
            miscompares++;
            $display("FAIL single_play: play=%b code=%0d q=%0d, required 1/4/0",
                     play_sound, sound_code, q_count);
        end
        tick();                                // N+3, WAIT_ACK
        start = 1'b1;
        bad_play = 0;
        repeat (20) begin
            if (play_sound) bad_play++;
            tick();
        end
        start = 1'b0;                          // cycle F
        repeat (7) begin
            tick();
            if (play_sound) bad_play++;
        end
        vectors++;
        if (busy !== 1'b1 || sound_code !== 3'd4) begin
            miscompares++;
            $display("FAIL single_gap: busy=%b code=%0d at F+7, required 1/4",
                     busy, sound_code);
        end
        tick();                                // F+8, IDLE
        vectors++;
        if (busy !== 1'b0 || bad_play != 0) begin
            miscompares++;
            $display("FAIL single_idle: busy=%b extra_plays=%0d at F+8, required 0/0",
                     busy, bad_play);
        end
        $display("single: code 4 played, idle at F+8");
    endtask

    task automatic test_simultaneous;
        int plays;
        pulse_ev(7'b0010011);
        vectors++;
        if (q_count !== 3'd1 || dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_queue: q=%0d dropped=%b, required 1/0", q_count, dropped);
        end
        tick();
        vectors++;
        if (play_sound !== 1'b1 || sound_code !== 3'd5) begin
            miscompares++;
            $display("FAIL simul_code: play=%b code=%0d, required 1/5", play_sound, sound_code);
        end
        wait_idle("simul_drain", plays);
        vectors++;
        if (plays != 0) begin
            miscompares++;
            $display("FAIL simul_extra: plays=%0d, required 0", plays);
        end
        $display("simultaneous: only code 5 queued");
    endtask

    task automatic test_timeout;
        int bad_play;
        int plays;
        ev = 7'b0000010;                       // cycle N: code 2
        tick();
        ev = 7'b0000100;                       // cycle N+1: code 3
        tick();
        ev = '0;                               // cycle N+2 = T
        vectors++;
        if (play_sound !== 1'b1 || sound_code !== 3'd2 || q_count !== 3'd1) begin
            miscompares++;
            $display("FAIL timeout_first: play=%b code=%0d q=%0d, required 1/2/1",
                     play_sound, sound_code, q_count);
        end
        bad_play = 0;
        repeat (23) begin                      // T+1 .. T+23
            tick();
            if (play_sound) bad_play++;
        end
        vectors++;
        if (bad_play != 0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_wait: early_plays=%0d busy=%b, required 0/1",
                     bad_play, busy);
        end
        tick();                                // T+24
        vectors++;
        if (play_sound !== 1'b1 || sound_code !== 3'd3) begin
            miscompares++;
            $display("FAIL timeout_next: play=%b code=%0d at T+24, required 1/3",
                     play_sound, sound_code);
        end
        wait_idle("timeout_drain", plays);
        vectors++;
        if (plays != 0) begin
            miscompares++;
            $display("FAIL timeout_retry: plays=%0d, required 0", plays);
        end
        $display("timeout: second entry issued 24 cycles after first");
    endtask

    task automatic test_overflow;
        int plays;
        pulse_ev(7'b0100000);                  // code 6 starts playing
        tick();
        tick();
        start = 1'b1;
        tick();                                // WAIT_DONE
        pulse_ev(7'b0000001);
        pulse_ev(7'b0000010);
        pulse_ev(7'b0000100);
        pulse_ev(7'b0001000);
        vectors++;
        if (q_count !== 3'd4 || dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_fill: q=%0d dropped=%b, required 4/0", q_count, dropped);
        end
        pulse_ev(7'b0010000);                  // code 5 into full queue
        vectors++;
        if (dropped !== 1'b1 || q_count !== 3'd4) begin
            miscompares++;
            $display("FAIL ovf_drop: dropped=%b q=%0d, required 1/4", dropped, q_count);
        end
        tick();
        vectors++;
        if (dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_drop_len: dropped=%b, required 0", dropped);
        end
        pulse_ev(7'b1000000);                  // code 7 overwrites tail
        vectors++;
        if (dropped !== 1'b0 || q_count !== 3'd4) begin
            miscompares++;
            $display("FAIL ovf_gameover: dropped=%b q=%0d, required 0/4", dropped, q_count);
        end
        start = 1'b0;
        play_one(3'd1, "ovf_1");
        play_one(3'd2, "ovf_2");
        play_one(3'd3, "ovf_3");
        play_one(3'd7, "ovf_4");
        wait_idle("ovf_drain", plays);
        vectors++;
        if (plays != 0) begin
            miscompares++;
            $display("FAIL ovf_extra: plays=%0d, required 0", plays);
        end
    endtask

    task automatic test_mute;
        int plays;
        pulse_ev(7'b0000001);
        tick();
        tick();
        start = 1'b1;
        tick();                                // WAIT_DONE
        pulse_ev(7'b0000010);
        pulse_ev(7'b0000100);
        pulse_ev(7'b0001000);
        vectors++;
        if (q_count !== 3'd3) begin
            miscompares++;
            $display("FAIL mute_fill: q=%0d, required 3", q_count);
        end
        mute = 1'b1;
        pulse_ev(7'b1000000);
        vectors++;
        if (q_count !== 3'd0 || dropped !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mute_flush: q=%0d dropped=%b busy=%b, required 0/0/1",
                     q_count, dropped, busy);
        end
        pulse_ev(7'b0010000);
        vectors++;
        if (q_count !== 3'd0 || dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL mute_ignore: q=%0d dropped=%b, required 0/0", q_count, dropped);
        end
        start = 1'b0;
        repeat (3) tick();
        mute = 1'b0;
        wait_idle("mute_drain", plays);
        vectors++;
        if (plays != 0) begin
            miscompares++;
            $display("FAIL mute_plays: plays=%0d, required 0", plays);
        end
        $display("mute: queue flushed, no further requests");
    endtask

    task automatic test_reset_mid;
        pulse_ev(7'b0100000);
        tick();
        tick();
        start = 1'b1;
        repeat (2) tick();                     // WAIT_DONE
        pulse_ev(7'b0000100);
        rst = 1'b1;
        tick();
        vectors++;
        if ({sound_code, play_sound, busy, q_count, dropped} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_mid: code=%0d play=%b busy=%b q=%0d drop=%b, required all 0",
                     sound_code, play_sound, busy, q_count, dropped);
        end
        rst = 1'b0;
        repeat (3) tick();
        start = 1'b0;
        repeat (3) tick();
        vectors++;
        if (busy !== 1'b0 || play_sound !== 1'b0 || q_count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_after: busy=%b play=%b q=%0d, required 0/0/0",
                     busy, play_sound, q_count);
        end
        $display("reset_mid: returned to reset values");
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_timeout();
        test_overflow();
        test_mute();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
